return_addr_stack: RTL and testbench



---
 rtl/return_addr_stack_pkg.sv | 15 +
 rtl/return_addr_stack.sv | 80 ++++++++
 tb/tb_return_addr_stack.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/return_addr_stack_pkg.sv
// Shared front-end typedefs: predecode control-flow classes produced per
// fetched instruction and consumed by the predecoder and the return stack.
package return_addr_stack_pkg;

    typedef enum logic [3:0] {
        PD_NONE = 4'd0,
        PD_BR   = 4'd1,
        PD_RET  = 4'd2,
        PD_J    = 4'd3,
        PD_JR   = 4'd4,
        PD_JAL  = 4'd5,
        PD_JALR = 4'd6
    } jump_t;

endpackage

// File: rtl/return_addr_stack.sv
// Return address stack: pushes pc+4 on calls, predicts the target of returns in
// the same cycle, and exports a tos/count checkpoint the backend can restore.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int LG_N = 3,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic [3:0]      fetch_pd,
    input  logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] ras_tgt,
    output logic            ras_tgt_valid,
    output logic [LG_N-1:0] ckpt_tos,
    output logic [LG_N:0]   ckpt_count,
    input  logic            restore,
    input  logic [LG_N-1:0] restore_tos,
    input  logic [LG_N:0]   restore_count
);

    localparam int N = 1 << LG_N;
    localparam logic [LG_N:0] N_CNT = (LG_N+1)'(N);

    logic [XLEN-1:0] mem [N];
    logic [LG_N-1:0] tos_reg, tos_next;
    logic [LG_N:0]   count_reg, count_next;
    logic            is_call, is_ret, write_en;
    logic [LG_N-1:0] write_addr;

    assign is_call    = fetch_valid && (fetch_pd == PD_JAL || fetch_pd == PD_JALR);
    assign is_ret     = fetch_valid && (fetch_pd == PD_RET);
    assign write_addr = tos_reg + LG_N'(1);

    always_comb begin
        tos_next   = tos_reg;
        count_next = count_reg;
        write_en   = 1'b0;
        if (restore) begin
            tos_next   = restore_tos;
            count_next = (restore_count > N_CNT) ? N_CNT : restore_count;
        end else if (is_call) begin
            // A full stack wraps onto the oldest entry; occupancy saturates.
            write_en   = 1'b1;
            tos_next   = write_addr;
            count_next = (count_reg == N_CNT) ? count_reg : count_reg + (LG_N+1)'(1);
        end else if (is_ret && count_reg != '0) begin
            tos_next   = tos_reg - LG_N'(1);
            count_next = count_reg - (LG_N+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos_reg   <= '0;
            count_reg <= '0;
        end else begin
            tos_reg   <= tos_next;
            count_reg <= count_next;
        end
    end

    // Storage is never cleared; count alone qualifies entries.
    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            mem[write_addr] <= fetch_pc + XLEN'(4);
        end
    end

    assign ras_tgt       = mem[tos_reg];
    assign ras_tgt_valid = is_ret && (count_reg != '0) && !restore;
    assign ckpt_tos      = tos_reg;
    assign ckpt_count    = count_reg;

    restore_count_legal: assert property (
        @(posedge clk) disable iff (reset) restore |-> (restore_count <= N_CNT)
    ) else $error("restore_count %0d exceeds stack depth %0d", restore_count, N);

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack: a reference stack model predicts
// each cycle's outputs into a scoreboard that is drained when outputs settle.
module tb_return_addr_stack;

    localparam int LG_N = 3;
    localparam int XLEN = 64;
    localparam int N    = 1 << LG_N;

    logic            clk;
    logic            reset;
    logic            fetch_valid;
    logic [3:0]      fetch_pd;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] ras_tgt;
    logic            ras_tgt_valid;
    logic [LG_N-1:0] ckpt_tos;
    logic [LG_N:0]   ckpt_count;
    logic            restore;
    logic [LG_N-1:0] restore_tos;
    logic [LG_N:0]   restore_count;

    return_addr_stack #(.LG_N(LG_N), .XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_valid   (fetch_valid),
        .fetch_pd      (fetch_pd),
        .fetch_pc      (fetch_pc),
        .ras_tgt       (ras_tgt),
        .ras_tgt_valid (ras_tgt_valid),
        .ckpt_tos      (ckpt_tos),
        .ckpt_count    (ckpt_count),
        .restore       (restore),
        .restore_tos   (restore_tos),
        .restore_count (restore_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            valid;
        logic [XLEN-1:0] tgt;
        logic [LG_N-1:0] tos;
        logic [LG_N:0]   count;
    } expect_t;

    expect_t exp_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int n_steps  = 0;

    // Reference model state
    logic [XLEN-1:0] m_mem [N];
    int              m_tos;
    int              m_count;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (step %0d)", tag, got, exp, n_steps);
        end
    endtask

    // One cycle: drive inputs, predict outputs, compare after settle, advance model.
    task automatic step(input logic rst, input logic fv, input logic [3:0] pd,
                        input logic [XLEN-1:0] pc, input logic rs,
                        input int rtos, input int rcnt);
        expect_t e, got_e;
        @(negedge clk);
        reset = rst; fetch_valid = fv; fetch_pd = pd; fetch_pc = pc;
        restore = rs; restore_tos = LG_N'(rtos); restore_count = (LG_N+1)'(rcnt);

        e.valid = fv && pd == 4'd2 && m_count != 0 && !rs;
        e.tgt   = m_mem[m_tos];
        e.tos   = LG_N'(m_tos);
        e.count = (LG_N+1)'(m_count);
        exp_q.push_back(e);

        #2;
        got_e = exp_q.pop_front();
        check("ckpt_tos", XLEN'(ckpt_tos), XLEN'(got_e.tos));
        check("ckpt_count", XLEN'(ckpt_count), XLEN'(got_e.count));
        check("ras_tgt_valid", XLEN'(ras_tgt_valid), XLEN'(got_e.valid));
        if (got_e.valid) check("ras_tgt", ras_tgt, got_e.tgt);
        $display("step %0d rst=%0b fv=%0b pd=%0d pc=%h rs=%0b -> tos=%0d cnt=%0d v=%0b tgt=%h",
                 n_steps, rst, fv, pd, pc, rs, ckpt_tos, ckpt_count, ras_tgt_valid, ras_tgt);
        n_steps++;

        if (rst) begin
            m_tos = 0; m_count = 0;
        end else if (rs) begin
            m_tos = rtos % N;
            m_count = (rcnt > N) ? N : rcnt;
        end else if (fv && (pd == 4'd5 || pd == 4'd6)) begin
            m_tos = (m_tos + 1) % N;
            m_mem[m_tos] = pc + 64'd4;
            if (m_count < N) m_count++;
        end else if (fv && pd == 4'd2 && m_count != 0) begin
            m_tos = (m_tos + N - 1) % N;
            m_count--;
        end
    endtask

    task automatic fetch(input logic [3:0] pd, input logic [XLEN-1:0] pc);
        step(1'b0, 1'b1, pd, pc, 1'b0, 0, 0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, '0, 1'b0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; fetch_valid = 1'b0; fetch_pd = '0; fetch_pc = '0;
        restore = 1'b0; restore_tos = '0; restore_count = '0;
        m_tos = 0; m_count = 0;
        for (int i = 0; i < N; i++) m_mem[i] = '0;
        repeat (2) @(posedge clk);

        // Ret on an empty stack after reset
        fetch(4'd2, 64'h1000);
        idle();

        // Single call/return pair
        fetch(4'd5, 64'h2000);
        fetch(4'd2, 64'h2100);
        idle();

        // Overflow by one, then drain past empty
        for (int i = 1; i <= 9; i++) fetch((i % 2 == 1) ? 4'd5 : 4'd6, 64'(i * 'h100));
        for (int i = 0; i < 9; i++) fetch(4'd2, 64'h5000);
        idle();

        // Checkpoint and restore
        step(1'b1, 1'b0, 4'd0, '0, 1'b0, 0, 0);
        fetch(4'd5, 64'h10);
        fetch(4'd6, 64'h20);
        step(1'b0, 1'b0, 4'd0, '0, 1'b1, 1, 1);
        fetch(4'd2, 64'h30);
        idle();

        // Restore wins over a concurrent call and suppresses a concurrent ret prediction
        step(1'b0, 1'b1, 4'd6, 64'h3000, 1'b1, 5, 3);
        step(1'b0, 1'b1, 4'd2, 64'h3100, 1'b1, 2, 2);
        idle();

        // Reset mid-sequence with a ret present
        for (int i = 0; i < 5; i++) fetch(4'd5, 64'h7000 + 64'(i * 16));
        step(1'b1, 1'b1, 4'd2, 64'h7100, 1'b0, 0, 0);
        fetch(4'd2, 64'h7200);

        // Random traffic with legal restores
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0)
                step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     {$urandom, $urandom}, 1'b1, $urandom_range(0, N - 1), $urandom_range(0, N));
            else if (r == 1)
                step(1'b1, 1'b1, 4'd2, 64'h0, 1'b0, 0, 0);
            else if (r < 8)
                fetch(4'd2, {$urandom, $urandom});
            else
                step(1'b0, 1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
                     {$urandom, $urandom}, 1'b0, 0, 0);
        end

        if (exp_q.size() != 0) check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
